// File: rtl/seq_restoring_divider.sv
// 8-bit unsigned sequential restoring divider: one quotient bit per clock,
// built around a single ripple borrow subtractor iterated over the operands.

module Rbs (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_c,
    output logic [7:0] o_diff,
    output logic       o_borrow
);
    logic [8:0] w_bw;

    always_comb begin
        w_bw    = '0;
        o_diff  = '0;
        w_bw[0] = i_c;
        for (int unsigned i = 0; i < 8; i++) begin
            o_diff[i]   = i_a[i] ^ i_b[i] ^ w_bw[i];
            w_bw[i + 1] = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_bw[i]);
        end
        o_borrow = w_bw[8];
    end
endmodule

module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    if (WIDTH != 8) begin : g_width_err
        $error("seq_restoring_divider: WIDTH must be 8 to match Rbs");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_q;
    logic [7:0] r_d;
    logic [7:0] r_r;
    logic [2:0] r_cnt;

    logic [7:0] w_t;
    logic [7:0] w_diff;
    logic       w_borrow;
    logic [7:0] w_r_next;
    logic [7:0] w_q_next;
    logic       w_zero;
    logic       w_last;

    assign w_t      = {r_r[6:0], r_q[7]};
    assign w_r_next = w_borrow ? w_t : w_diff;
    assign w_q_next = {r_q[6:0], ~w_borrow};
    assign w_zero   = (r_d == '0);
    assign w_last   = (r_cnt == 3'd7);

    Rbs u_rbs (
        .i_a      (w_t),
        .i_b      (r_d),
        .i_c      (1'b0),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_zero || w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // A zero divisor spends its first cycle in RUN only to inspect the
    // captured value; it is not a division in progress, so busy stays low.
    always_comb begin
        busy = (r_state == S_RUN) && !w_zero;
        done = (r_state == S_DONE);
    end

    // Results are written on the edge entering DONE so they are valid with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_q         <= dividend;
                        r_d         <= divisor;
                        r_r         <= '0;
                        r_cnt       <= '0;
                        div_by_zero <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_zero) begin
                        quotient    <= '1;
                        remainder   <= r_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        r_q   <= w_q_next;
                        r_r   <= w_r_next;
                        r_cnt <= r_cnt + 3'd1;
                        if (w_last) begin
                            quotient  <= w_q_next;
                            remainder <= w_r_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
